// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, CR bit positions,
// opcodes and the opcode -> extension-word-count table.
package fetch_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_FETCH0 = 4'd0,
        ST_FETCHX = 4'd1,
        ST_EXEC   = 4'd2,
        ST_HALT   = 4'd3
    } seq_state_e;

    localparam int CR_HLT  = 0;
    localparam int CR_SKIP = 1;

    localparam logic [7:0] OP_HLT    = 8'h01;
    localparam logic [7:0] OP_CND    = 8'h02;
    localparam logic [7:0] OP_LIMM32 = 8'h10;
    localparam logic [7:0] OP_LBSET  = 8'h11;

    function automatic logic [7:0] ext_count(input logic [7:0] op);
        return (op == OP_LIMM32 || op == OP_LBSET) ? 8'd1 : 8'd0;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_state.sv
// Combinational next-state / next-CR / next-pc logic for fetch_sequencer.
// No storage here; every register lives in the top.
module seq_next_state
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int MAX_EXT = 2,
    parameter int CNT_W   = 2
) (
    input  seq_state_e             state_q,
    input  logic [7:0]             cr_q,
    input  logic [PC_W-1:0]        pc_q,
    input  logic [CNT_W-1:0]       left_q,
    input  logic [CNT_W-1:0]       idx_q,
    input  logic                   step_q,
    input  logic [7:0]             rdata_op,
    input  logic [7:0]             exec_op,
    input  logic                   mem_ready,
    input  logic                   cond_lsb,
    input  logic                   exec_done,
    input  logic                   jump_en,
    input  logic [PC_W-1:0]        jump_addr,
    input  logic                   resume,
    input  logic                   step,
    output seq_state_e             state_d,
    output logic [7:0]             cr_d,
    output logic [PC_W-1:0]        pc_d,
    output logic [CNT_W-1:0]       left_d,
    output logic [CNT_W-1:0]       idx_d,
    output logic                   step_d,
    output logic                   capture,
    output logic [CNT_W-1:0]       cap_slice
);

    logic [7:0]       raw_cnt;
    logic [CNT_W-1:0] n_ext;
    logic             fetched;

    always_comb begin
        state_d   = state_q;
        cr_d      = cr_q;
        pc_d      = pc_q;
        left_d    = left_q;
        idx_d     = idx_q;
        step_d    = step_q;
        capture   = 1'b0;
        cap_slice = '0;
        fetched   = 1'b0;
        raw_cnt   = ext_count(rdata_op);
        n_ext     = (raw_cnt > 8'(MAX_EXT)) ? CNT_W'(MAX_EXT) : raw_cnt[CNT_W-1:0];

        case (state_q)
            ST_FETCH0: if (mem_ready) begin
                capture = 1'b1;
                pc_d    = pc_q + 1'b1;
                if (n_ext != '0) begin
                    left_d  = n_ext;
                    idx_d   = CNT_W'(1);
                    state_d = ST_FETCHX;
                end else begin
                    fetched = 1'b1;
                end
            end
            ST_FETCHX: if (mem_ready) begin
                capture   = 1'b1;
                cap_slice = idx_q;
                pc_d      = pc_q + 1'b1;
                idx_d     = idx_q + 1'b1;
                left_d    = left_q - 1'b1;
                fetched   = (left_q == CNT_W'(1));
            end
            ST_EXEC: begin
                if (exec_op == OP_HLT) begin
                    cr_d[CR_HLT] = 1'b1;
                    step_d       = 1'b0;
                    state_d      = ST_HALT;
                end else if (exec_done) begin
                    if (jump_en) pc_d = jump_addr;
                    if (exec_op == OP_CND) cr_d[CR_SKIP] = ~cond_lsb;
                    // A single-stepped instruction lands back in HALT.
                    if (step_q) cr_d[CR_HLT] = 1'b1;
                    state_d = step_q ? ST_HALT : ST_FETCH0;
                    step_d  = 1'b0;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    cr_d[CR_HLT] = 1'b0;
                    state_d      = ST_FETCH0;
                end else if (step) begin
                    cr_d[CR_HLT] = 1'b0;
                    step_d       = 1'b1;
                    state_d      = ST_FETCH0;
                end
            end
            default: state_d = ST_FETCH0;
        endcase

        // Whole instruction in hand: run it, or drop it if SKIP is armed.
        if (fetched) begin
            if (cr_q[CR_SKIP]) begin
                cr_d[CR_SKIP] = 1'b0;
                if (step_q) cr_d[CR_HLT] = 1'b1;
                state_d = step_q ? ST_HALT : ST_FETCH0;
                step_d  = 1'b0;
            end else begin
                state_d = ST_EXEC;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence FSM: fetches an opcode word plus extension words,
// hands it to the datapath, handles skip/jump/halt. FETCH_SEQUENCER_STEP_EN adds single-step.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int DATA_W  = 32,
    parameter int MAX_EXT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ready,
    output logic                         mem_req,
    output logic [PC_W-1:0]              mem_addr,
    input  logic                         cond_lsb,
    input  logic                         exec_done,
    input  logic                         jump_en,
    input  logic [PC_W-1:0]              jump_addr,
`ifdef FETCH_SEQUENCER_STEP_EN
    input  logic                         step,
`endif
    input  logic                         resume,
    output logic [(MAX_EXT+1)*DATA_W-1:0] instr,
    output logic [3:0]                   state,
    output logic [7:0]                   cr,
    output logic [PC_W-1:0]              pc,
    output logic                         exec_start
);

    localparam int CNT_W = $clog2(MAX_EXT + 2);

    seq_state_e                      state_q, state_d;
    logic [7:0]                      cr_q, cr_d;
    logic [PC_W-1:0]                 pc_q, pc_d;
    logic [CNT_W-1:0]                left_q, left_d, idx_q, idx_d, cap_slice;
    logic                            step_q, step_d, step_in, capture;
    logic                            exec_start_q, exec_start_d;
    logic [MAX_EXT:0][DATA_W-1:0]    instr_q, instr_d;

`ifdef FETCH_SEQUENCER_STEP_EN
    assign step_in = step;
`else
    assign step_in = 1'b0;
`endif

    seq_next_state #(.PC_W(PC_W), .MAX_EXT(MAX_EXT), .CNT_W(CNT_W)) u_next (
        .state_q   (state_q),
        .cr_q      (cr_q),
        .pc_q      (pc_q),
        .left_q    (left_q),
        .idx_q     (idx_q),
        .step_q    (step_q),
        .rdata_op  (mem_rdata[DATA_W-1 -: 8]),
        .exec_op   (instr_q[0][DATA_W-1 -: 8]),
        .mem_ready (mem_ready),
        .cond_lsb  (cond_lsb),
        .exec_done (exec_done),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .resume    (resume),
        .step      (step_in),
        .state_d   (state_d),
        .cr_d      (cr_d),
        .pc_d      (pc_d),
        .left_d    (left_d),
        .idx_d     (idx_d),
        .step_d    (step_d),
        .capture   (capture),
        .cap_slice (cap_slice)
    );

    always_comb begin
        instr_d = instr_q;
        if (capture) instr_d[cap_slice] = mem_rdata;
        exec_start_d = (state_d == ST_EXEC) && (state_q != ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_FETCH0;
            cr_q         <= '0;
            pc_q         <= '0;
            left_q       <= '0;
            idx_q        <= '0;
            step_q       <= 1'b0;
            exec_start_q <= 1'b0;
            instr_q      <= '0;
        end else begin
            state_q      <= state_d;
            cr_q         <= cr_d;
            pc_q         <= pc_d;
            left_q       <= left_d;
            idx_q        <= idx_d;
            step_q       <= step_d;
            exec_start_q <= exec_start_d;
            instr_q      <= instr_d;
        end
    end

    assign mem_req    = (state_q == ST_FETCH0) || (state_q == ST_FETCHX);
    assign mem_addr   = mem_req ? pc_q : '0;
    assign instr      = instr_q;
    assign state      = state_q;
    assign cr         = cr_q;
    assign pc         = pc_q;
    assign exec_start = exec_start_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: skip, stall, jump, halt/resume, pc wrap, reset mid-fetch.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam logic [31:0] W_LIMM = 32'h1000_0001;
    localparam logic [31:0] W_EXT  = 32'hCAFE_F00D;
    localparam logic [31:0] W_CND  = 32'h0200_0000;
    localparam logic [31:0] W_ADD  = 32'h2000_0000;
    localparam logic [31:0] W_HLT  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset, mem_ready, mem_req, cond_lsb, exec_done, jump_en, resume, exec_start, step;
    logic [31:0] mem_rdata;
    logic [15:0] mem_addr, jump_addr, pc;
    logic [95:0] instr;
    logic [3:0]  state;
    logic [7:0]  cr;
    logic [31:0] mem [256];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:0]];

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .cond_lsb(cond_lsb), .exec_done(exec_done),
        .jump_en(jump_en), .jump_addr(jump_addr),
`ifdef FETCH_SEQUENCER_STEP_EN
        .step(step),
`endif
        .resume(resume), .instr(instr), .state(state), .cr(cr), .pc(pc),
        .exec_start(exec_start)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = W_LIMM; mem[8'h01] = W_EXT; mem[8'h02] = W_CND;
        mem[8'h03] = W_ADD;  mem[8'h04] = W_ADD; mem[8'h40] = W_HLT;
        mem[8'h41] = W_ADD;  mem[8'hFE] = W_LIMM; mem[8'hFF] = W_ADD;
        reset = 1'b0; mem_ready = 1'b1; cond_lsb = 1'b1; exec_done = 1'b0;
        jump_en = 1'b0; jump_addr = '0; resume = 1'b0; step = 1'b0;

        tick(2);
        chk("rst_state", state, ST_FETCH0);
        chk("rst_pc", pc, 0);
        chk("rst_cr", cr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_xstart", exec_start, 0);
        chk("rst_memreq", mem_req, 1);
        reset = 1'b1;

        // LIMM32 executes normally: two words then EXEC
        tick(1);
        chk("limm_fx", state, ST_FETCHX);
        tick(1);
        chk("limm_exec", state, ST_EXEC);
        chk("limm_xstart", exec_start, 1);
        chk("limm_pc", pc, 2);
        chk("limm_instr", instr, {32'h0, W_EXT, W_LIMM});
        tick(1);
        chk("exec_hold", state, ST_EXEC);
        chk("xstart_pulse", exec_start, 0);
        exec_done = 1'b1;
        tick(1);
        exec_done = 1'b0;
        chk("exec_done_f0", state, ST_FETCH0);
        chk("exec_done_pc", pc, 2);

        // CND false + jump back to 0 arms SKIP
        tick(1);
        chk("cnd_exec", state, ST_EXEC);
        exec_done = 1'b1; cond_lsb = 1'b0; jump_en = 1'b1; jump_addr = 16'h0000;
        tick(1);
        exec_done = 1'b0; jump_en = 1'b0;
        chk("cnd_skip_cr", cr, 8'h02);
        chk("cnd_jump_pc", pc, 0);

        // Skipped LIMM32 still fetches both words
        tick(1);
        chk("skip_fx_xs", exec_start, 0);
        tick(1);
        chk("skip_state", state, ST_FETCH0);
        chk("skip_pc", pc, 2);
        chk("skip_cr", cr, 8'h00);
        chk("skip_xstart", exec_start, 0);

        // CND false then ADD: ADD dropped
        tick(1);
        exec_done = 1'b1;
        tick(1);
        exec_done = 1'b0;
        chk("cnd2_cr", cr, 8'h02);
        chk("cnd2_pc", pc, 3);

        // Memory stall for 5 cycles at pc=3
        mem_ready = 1'b0;
        tick(5);
        chk("stall_pc", pc, 3);
        chk("stall_state", state, ST_FETCH0);
        chk("stall_req", mem_req, 1);
        chk("stall_addr", mem_addr, 3);
        chk("stall_instr", instr[31:0], W_CND);
        mem_ready = 1'b1;
        tick(1);
        chk("add_skip_state", state, ST_FETCH0);
        chk("add_skip_pc", pc, 4);
        chk("add_skip_cr", cr, 0);
        chk("add_skip_xs", exec_start, 0);

        // Jump to 0x0040
        tick(1);
        chk("add_exec", exec_start, 1);
        exec_done = 1'b1; jump_en = 1'b1; jump_addr = 16'h0040;
        tick(1);
        exec_done = 1'b0; jump_en = 1'b0;
        chk("jump_addr", mem_addr, 16'h0040);

        // HLT, frozen, resume
        tick(1);
        chk("hlt_exec", state, ST_EXEC);
        tick(1);
        chk("hlt_state", state, ST_HALT);
        chk("hlt_cr", cr, 8'h01);
        exec_done = 1'b1; jump_en = 1'b1; jump_addr = 16'h1234;
        tick(10);
        exec_done = 1'b0; jump_en = 1'b0;
        chk("halt_pc", pc, 16'h0041);
        chk("halt_state", state, ST_HALT);
        chk("halt_req", mem_req, 0);
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        chk("resume_state", state, ST_FETCH0);
        chk("resume_cr", cr, 8'h00);

        // Jump to 0xFFFF; fetch there wraps pc to 0
        tick(1);
        exec_done = 1'b1; jump_en = 1'b1; jump_addr = 16'hFFFF;
        tick(1);
        exec_done = 1'b0; jump_en = 1'b0;
        chk("pre_wrap_pc", pc, 16'hFFFF);
        tick(1);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_state", state, ST_EXEC);

        // Reset in the middle of FETCHX at pc=0xFFFF
        exec_done = 1'b1; jump_en = 1'b1; jump_addr = 16'hFFFE;
        tick(1);
        exec_done = 1'b0; jump_en = 1'b0;
        tick(1);
        mem_ready = 1'b0;
        chk("fx_state", state, ST_FETCHX);
        chk("fx_pc", pc, 16'hFFFF);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("rst_fx_pc", pc, 0);
        chk("rst_fx_state", state, ST_FETCH0);
        chk("rst_fx_instr", instr, 0);
        chk("rst_fx_cr", cr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter and memory-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width; opcode = bits [DATA_W-1:DATA_W-8].
REQ-003 SHALL have parameter MAX_EXT, default 2, maximum number of extension words per instruction.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port mem_rdata  input  DATA_W  instruction memory read data.
REQ-007 SHALL have port mem_ready  input  1  mem_rdata valid for the current mem_addr this cycle.
REQ-008 SHALL have port mem_req  output  1  fetch request; high in FETCH0 and FETCHX only.
REQ-009 SHALL have port mem_addr  output  PC_W  equals pc while mem_req is high, else 0.
REQ-010 SHALL have port cond_lsb  input  1  LSB of the CND operand register.
REQ-011 SHALL have port exec_done  input  1  datapath finished the current instruction.
REQ-012 SHALL have ports jump_en  input  1 and jump_addr  input  PC_W  branch request, sampled with exec_done.
REQ-013 SHALL have port resume  input  1  leave HALT.
REQ-014 SHALL have port instr  output  (MAX_EXT+1)*DATA_W  word 0 in the low DATA_W bits, extension k in slice k.
REQ-015 SHALL have ports state  output  4, cr  output  8 (bit0 HLT, bit1 SKIP, others 0), pc  output  PC_W.
REQ-016 SHALL have port exec_start  output  1  one-cycle pulse on entry to EXEC.

Function
REQ-017 SHALL implement states FETCH0, FETCHX, EXEC, HALT.
REQ-018 FETCH0 SHALL hold state and pc while mem_ready=0; when mem_ready=1 it SHALL load instr word 0, increment pc, and set ext count from the opcode table.
REQ-019 On a FETCH0 capture, ext count >0 SHALL go to FETCHX; ext count 0 SHALL go to EXEC if SKIP=0, else to FETCH0 with SKIP cleared and no exec_start.
REQ-020 FETCHX SHALL capture one word per mem_ready=1 cycle into the next slice, incrementing pc; after the last word it SHALL go to EXEC if SKIP=0, else to FETCH0 with SKIP cleared.
REQ-021 Extension words SHALL always be fetched, even when skipped, so pc passes the whole instruction.
REQ-022 pc SHALL wrap from 2^PC_W-1 to 0 without a flag.
REQ-023 EXEC SHALL hold until exec_done=1; then it SHALL go to FETCH0, loading pc from jump_addr if jump_en=1.
REQ-024 EXEC of OP_HLT SHALL ignore exec_done, set HLT and go to HALT after one cycle.
REQ-025 EXEC of OP_CND with exec_done=1 SHALL set SKIP if cond_lsb=0, else clear it.
REQ-026 HALT SHALL freeze pc, instr and SKIP; resume=1 SHALL clear HLT and go to FETCH0 on the next edge.
REQ-027 Slices not filled by the current instruction SHALL hold their previous value.

Reset
REQ-028 reset=0 at a clock edge SHALL set state FETCH0, pc 0, cr 0, instr 0 and exec_start 0, overriding every other input.
REQ-029 Reset during FETCHX, EXEC or HALT SHALL abandon the instruction with no partial side effect after the edge.

Configuration
REQ-030 Macro FETCH_SEQUENCER_STEP_EN defined SHALL add port step  input  1; step=1 in HALT SHALL run exactly one instruction, then return to HALT with HLT set.
REQ-031 Without FETCH_SEQUENCER_STEP_EN, the step port SHALL be absent; only resume leaves HALT.

Structure
REQ-032 A shared package SHALL hold state encodings, CR bit indices, opcodes (OP_HLT, OP_CND, OP_LIMM32, OP_LBSET) and an ext-count function: LIMM32/LBSET give 1, all others give 0.
REQ-033 One sub-module, seq_next_state, SHALL hold the combinational next-state/next-CR logic; registers stay in fetch_sequencer.

Verification
REQ-034 Test: mem_ready stuck 0 for 5 cycles in FETCH0 at pc=3 -> pc stays 3, no capture, mem_req stays 1.
REQ-035 Test: LIMM32 at pc=0 with SKIP=1 -> two fetches, pc=2, no exec_start, SKIP=0.
REQ-036 Test: CND with cond_lsb=0, then a single-word ADD -> ADD not executed, pc advances by 1.
REQ-037 Test: jump_en=1, jump_addr=0x0040 with exec_done -> next mem_addr=0x0040.
REQ-038 Test: HLT -> cr=0x01 and pc frozen for 10 cycles; resume=1 -> FETCH0, cr=0x00.
REQ-039 Test: reset=0 mid-FETCHX at pc=0xFFFF -> pc=0, state FETCH0, instr=0; separately, pc=0xFFFF fetch wraps to 0.
